// File: rtl/fft_pkg.sv
// Shared types, twiddle ROM and index helpers for the sequential radix-2 FFT.
package fft_pkg;

  localparam int unsigned TW_W = 16;
  localparam int unsigned TW_N = 8;

  typedef struct packed {
    logic signed [TW_W-1:0] re;
    logic signed [TW_W-1:0] im;
  } cplx16_t;

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} fft_state_e;

  // W^k = cos(2*pi*k/16) - j*sin(2*pi*k/16) in Q2.14
  localparam cplx16_t TWIDDLE [TW_N] = '{
    '{re:  16'sd16384, im:  16'sd0},
    '{re:  16'sd15137, im: -16'sd6270},
    '{re:  16'sd11585, im: -16'sd11585},
    '{re:  16'sd6270,  im: -16'sd15137},
    '{re:  16'sd0,     im: -16'sd16384},
    '{re: -16'sd6270,  im: -16'sd15137},
    '{re: -16'sd11585, im: -16'sd11585},
    '{re: -16'sd15137, im: -16'sd6270}
  };

  // Reverse the low 'bits' bits of n; bits above that come back as zero.
  function automatic logic [3:0] bitrev(input logic [3:0] n, input int unsigned bits);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < int'(bits)) r = {r[2:0], n[i]};
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_butterfly.sv
// Combinational radix-2 DIT butterfly: a' = a + W*b, b' = a - W*b, rounded Q2.14 twiddle product.
module fft_butterfly
  import fft_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  cplx16_t          w,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out
);

  localparam int unsigned H  = WIDTH / 2;
  localparam int unsigned PW = H + TW_W + 2;
  localparam logic signed [PW-1:0] RND = PW'(8192);

  logic signed [H-1:0]  ar, ai, br, bi;
  logic signed [PW-1:0] pr, pi;
  logic        [H-1:0]  tr, ti;

  assign ar = a[WIDTH-1:H];
  assign ai = a[H-1:0];
  assign br = b[WIDTH-1:H];
  assign bi = b[H-1:0];

  assign pr = PW'(br) * PW'(w.re) - PW'(bi) * PW'(w.im);
  assign pi = PW'(br) * PW'(w.im) + PW'(bi) * PW'(w.re);

  // Round to nearest, drop the 14 fraction bits, wrap to H bits
  assign tr = H'((pr + RND) >>> 14);
  assign ti = H'((pi + RND) >>> 14);

  assign a_out = {H'(ar + tr), H'(ai + ti)};
  assign b_out = {H'(ar - tr), H'(ai - ti)};

endmodule

// File: rtl/n_point_fft_seq.sv
// Sequential in-place radix-2 DIT FFT: captures on reset, one butterfly per clock, parallel bins out.
module n_point_fft_seq
  import fft_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SAMPLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sampleRec [SAMPLES-1:0],
  output logic             out_valid,
  output logic [WIDTH-1:0] outputs   [SAMPLES-1:0]
);

  localparam int unsigned LOG2N = $clog2(SAMPLES);
  localparam int unsigned AW    = LOG2N;
  localparam int unsigned BW    = (LOG2N > 1) ? LOG2N - 1 : 1;
  localparam logic [1:0]    LAST_STAGE = 2'(LOG2N - 1);
  localparam logic [BW-1:0] LAST_BFLY  = BW'(SAMPLES / 2 - 1);

  if (!(SAMPLES == 2 || SAMPLES == 4 || SAMPLES == 8 || SAMPLES == 16)) begin : g_bad_samples
    $error("n_point_fft_seq: SAMPLES must be 2, 4, 8 or 16");
  end
  if ((WIDTH % 2) != 0) begin : g_bad_width
    $error("n_point_fft_seq: WIDTH must be even");
  end

  fft_state_e                          state;
  logic [1:0]                          stage;
  logic [BW-1:0]                       bfly;
  logic [SAMPLES-1:0][WIDTH-1:0]       work;
  logic [SAMPLES-1:0][WIDTH-1:0]       out_q;

  logic [AW-1:0]    idx_a, idx_b;
  logic [2:0]       tw_idx;
  logic [WIDTH-1:0] bf_a, bf_b;

  // Pair addressing: top = (b/span)*2*span + b%span, bottom = top + span
  assign idx_a  = AW'(((32'(bfly) >> stage) << (32'(stage) + 32'd1))
                    | (32'(bfly) & ((32'd1 << stage) - 32'd1)));
  assign idx_b  = AW'(32'(idx_a) + (32'd1 << stage));
  assign tw_idx = 3'((32'(bfly) & ((32'd1 << stage) - 32'd1)) << (32'd3 - 32'(stage)));

  fft_butterfly #(.WIDTH(WIDTH)) u_bfly (
    .a     (work[idx_a]),
    .b     (work[idx_b]),
    .w     (TWIDDLE[tw_idx]),
    .a_out (bf_a),
    .b_out (bf_b)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < SAMPLES; n++) begin
        work[AW'(bitrev(4'(n), LOG2N))] <= sampleRec[n];
      end
      stage     <= '0;
      bfly      <= '0;
      state     <= COMPUTE;
      out_valid <= 1'b0;
      out_q     <= '0;
    end else begin
      case (state)
        COMPUTE: begin
          work[idx_a] <= bf_a;
          work[idx_b] <= bf_b;
          if (bfly == LAST_BFLY) begin
            bfly <= '0;
            if (stage == LAST_STAGE) state <= DONE;
            else                     stage <= stage + 2'd1;
          end else begin
            bfly <= bfly + BW'(1);
          end
        end
        DONE: begin
          out_q     <= work;
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int k = 0; k < SAMPLES; k++) outputs[k] = out_q[k];
  end

endmodule

// File: tb/tb_n_point_fft_seq.sv
// Randomised and directed bench for n_point_fft_seq against a residue-split recursive DFT model.
module tb_n_point_fft_seq;

  localparam int N = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] sample_rec [N-1:0];
  logic        out_valid;
  logic [31:0] outputs [N-1:0];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  n_point_fft_seq #(.WIDTH(32), .SAMPLES(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .sampleRec (sample_rec),
    .out_valid (out_valid),
    .outputs   (outputs)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int wrap16(input longint v);
    shortint s;
    s = shortint'(v);
    return int'(s);
  endfunction

  // Length-L DFT of residue class r built from two length-L/2 DFTs of classes r and r+N/L.
  function automatic void ref_fft(input logic [31:0] x [N-1:0], output logic [31:0] y [N-1:0]);
    int cr [N][N];
    int ci [N][N];
    int nr [N][N];
    int ni [N][N];
    for (int r = 0; r < N; r++) begin
      cr[r][0] = int'($signed(x[r][31:16]));
      ci[r][0] = int'($signed(x[r][15:0]));
    end
    for (int len = 2; len <= N; len *= 2) begin
      int half, groups;
      half   = len / 2;
      groups = N / len;
      for (int r = 0; r < groups; r++) begin
        for (int k = 0; k < half; k++) begin
          real    ang;
          int     wr, wi, tr, ti;
          longint pr, pim;
          ang = 2.0 * 3.14159265358979 * real'(k) / real'(len);
          wr  = int'($cos(ang) * 16384.0);
          wi  = -int'($sin(ang) * 16384.0);
          pr  = longint'(cr[r+groups][k]) * wr - longint'(ci[r+groups][k]) * wi;
          pim = longint'(cr[r+groups][k]) * wi + longint'(ci[r+groups][k]) * wr;
          tr  = wrap16((pr + 8192) >>> 14);
          ti  = wrap16((pim + 8192) >>> 14);
          nr[r][k]      = wrap16(longint'(cr[r][k] + tr));
          ni[r][k]      = wrap16(longint'(ci[r][k] + ti));
          nr[r][k+half] = wrap16(longint'(cr[r][k] - tr));
          ni[r][k+half] = wrap16(longint'(ci[r][k] - ti));
        end
      end
      cr = nr;
      ci = ni;
    end
    for (int k = 0; k < N; k++) y[k] = {16'(cr[0][k]), 16'(ci[0][k])};
  endfunction

  // One reset-high edge capturing vec; checks the cleared state right after it.
  task automatic pulse_reset(input logic [31:0] vec [N-1:0], input string tag);
    @(negedge clk);
    sample_rec = vec;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq({tag, "_rst_valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, "_rst_out"}, outputs[5], 32'd0);
  endtask

  task automatic wait_and_check(input logic [31:0] exp [N-1:0], input string tag);
    int lat;
    lat = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        lat = c;
        break;
      end
    end
    check_eq({tag, "_latency"}, 32'(lat), 32'd33);
    for (int k = 0; k < N; k++) check_eq($sformatf("%s_bin%0d", tag, k), outputs[k], exp[k]);
  endtask

  task automatic run_fft(input logic [31:0] vec [N-1:0], input logic [31:0] exp [N-1:0],
                         input string tag);
    pulse_reset(vec, tag);
    wait_and_check(exp, tag);
  endtask

  initial begin
    logic [31:0] vec [N-1:0];
    logic [31:0] vec2 [N-1:0];
    logic [31:0] exp [N-1:0];

    for (int k = 0; k < N; k++) sample_rec[k] = '0;
    repeat (2) @(negedge clk);

    // All zero
    for (int k = 0; k < N; k++) begin vec[k] = '0; exp[k] = '0; end
    run_fft(vec, exp, "zero");

    // Impulse
    for (int k = 0; k < N; k++) begin vec[k] = '0; exp[k] = 32'h0064_0000; end
    vec[0] = 32'h0064_0000;
    run_fft(vec, exp, "impulse");

    // DC real
    for (int k = 0; k < N; k++) begin vec[k] = 32'h0064_0000; exp[k] = '0; end
    exp[0] = 32'h0640_0000;
    run_fft(vec, exp, "dc_re");

    // DC imaginary
    for (int k = 0; k < N; k++) begin vec[k] = 32'h0000_00C8; exp[k] = '0; end
    exp[0] = 32'h0000_0C80;
    run_fft(vec, exp, "dc_im");

    // Alternating real, then hold
    for (int k = 0; k < N; k++) begin
      vec[k] = (k % 2 == 0) ? {16'sd100, 16'sd0} : {-16'sd100, 16'sd0};
      exp[k] = '0;
    end
    exp[8] = {16'd1600, 16'd0};
    run_fft(vec, exp, "alt");
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (c % 10 == 9) check_eq($sformatf("alt_hold%0d", c), 32'(out_valid), 32'd1);
    end
    check_eq("alt_hold_bin8", outputs[8], exp[8]);

    // Mid-run restart: DC aborted at cycle 10 by an impulse capture
    for (int k = 0; k < N; k++) vec[k] = 32'h0064_0000;
    pulse_reset(vec, "restart_dc");
    repeat (9) @(negedge clk);
    check_eq("restart_mid_valid", 32'(out_valid), 32'd0);
    for (int k = 0; k < N; k++) begin vec[k] = '0; exp[k] = 32'h0064_0000; end
    vec[0] = 32'h0064_0000;
    run_fft(vec, exp, "restart");

    // Reset held three edges with changing inputs: last capture wins
    for (int k = 0; k < N; k++) vec[k] = 32'h0064_0000;
    @(negedge clk);
    sample_rec = vec;
    reset = 1'b1;
    @(negedge clk);
    for (int k = 0; k < N; k++) vec[k] = 32'h0000_00C8;
    sample_rec = vec;
    @(negedge clk);
    for (int k = 0; k < N; k++) vec[k] = {16'(k * 10), 16'(-k * 7)};
    sample_rec = vec;
    @(negedge clk);
    reset = 1'b0;
    ref_fft(vec, exp);
    wait_and_check(exp, "held");

    // Random vectors against the model
    for (int t = 0; t < 10; t++) begin
      for (int k = 0; k < N; k++) begin
        int re, im;
        re = int'($urandom_range(2000)) - 1000;
        im = int'($urandom_range(2000)) - 1000;
        vec2[k] = {16'(re), 16'(im)};
      end
      ref_fft(vec2, exp);
      run_fft(vec2, exp, $sformatf("rand%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
